// File: rtl/uart_rxtx.sv
// ============================================================================
// uart_rxtx
// ----------------------------------------------------------------------------
// Fixed-format 8N1 serial transceiver. It contains one receiver and one
// transmitter that share the clock and the bit-period divider. This is the
// serial engine behind the SoC UART register block.
//
// Parameters
//   CLK_FRE        system clock frequency in MHz
//   BAUD_RATE      line rate in bit/s
//                  The bit period is CYCLE = CLK_FRE*1e6/BAUD_RATE clocks,
//                  using integer division. CYCLE must be at least 2.
//
// Ports
//   clk            system clock; all logic runs on the rising edge
//   reset          synchronous, active-high
//   rx_pin         serial input, idle high, asynchronous to clk
//   rx_data        last correctly received byte
//   rx_data_valid  high while rx_data holds an unconsumed byte
//   rx_data_ready  consumer accepts rx_data when valid & ready
//   tx_data        byte to transmit, sampled only at the accept edge
//   tx_data_valid  producer offers tx_data
//   tx_data_ready  transmitter idle; doubles as "transmitter empty"
//   tx_pin         serial output, idle high
//   loopback       (only with UART_LOOPBACK_EN) echo received bytes on TX
//
// Build option
//   UART_LOOPBACK_EN  adds the loopback input. When loopback=1, every freshly
//                     received byte is offered to the transmitter in place of
//                     tx_data/tx_data_valid.
// ============================================================================
module uart_rxtx #(
    parameter int CLK_FRE   = 30,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
`ifdef UART_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    localparam int CYCLE = (CLK_FRE * 1000000) / BAUD_RATE;
    localparam int CNT_W = (CYCLE > 2) ? $clog2(CYCLE) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // ------------------------------------------------------------------
    // Signal declarations
    // ------------------------------------------------------------------
    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic [7:0]       tx_src_data;
    logic             tx_src_valid;

    logic             rx_meta, rx_sync;
    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             rx_byte_done;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------

    // Two-flop synchronizer for the asynchronous serial input. The flops
    // reset to the idle level so that reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    // Receiver next-state logic. START waits half a bit and re-checks the
    // line, which rejects short glitches. That wait also places every later
    // sample, one full bit apart, at the centre of its bit. A stop bit that
    // reads 0 is a framing error. The byte is dropped and the receiver waits
    // for the line to return high, so it does not resynchronise in the
    // middle of a break.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_byte_done = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_cnt_nxt   = CNT_ZERO;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt = CNT_ZERO;
                    rx_bit_nxt = 3'd0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = CNT_ZERO;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = CNT_ZERO;
                    if (rx_sync) begin
                        rx_byte_done = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync) begin
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // Output holding register and valid flag. A completing byte takes
    // priority over a handshake on the same edge. On overrun the newer byte
    // replaces the old one and valid stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
        end else if (rx_byte_done) begin
            rx_data       <= rx_shift;
            rx_data_valid <= 1'b1;
        end else if (rx_data_valid && rx_data_ready) begin
            rx_data_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter source selection
    // ------------------------------------------------------------------
`ifdef UART_LOOPBACK_EN
    logic rx_new_byte;

    // One-cycle marker that is high on the first cycle of each new
    // rx_data_valid. In loopback it acts as the echo request. A byte that is
    // never consumed is therefore echoed once, not repeatedly, and a byte
    // that lands while the transmitter is busy is simply not echoed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_new_byte <= 1'b0;
        end else begin
            rx_new_byte <= rx_byte_done;
        end
    end

    // Loopback mux: in loopback the external producer is ignored.
    always_comb begin
        tx_src_data  = tx_data;
        tx_src_valid = tx_data_valid;
        if (loopback) begin
            tx_src_data  = rx_data;
            tx_src_valid = rx_new_byte;
        end
    end
`else
    assign tx_src_data  = tx_data;
    assign tx_src_valid = tx_data_valid;
`endif

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------

    // Transmitter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
        end
    end

    // Transmitter next-state logic and line decode. Ready is a pure decode
    // of IDLE. A producer that drives valid from ready therefore gets
    // exactly one accept: ready falls on the edge that takes the byte.
    // Each line state lasts exactly CYCLE clocks.
    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt;
        tx_bit_nxt    = tx_bit;
        tx_shift_nxt  = tx_shift;
        tx_data_ready = (tx_state == TX_IDLE);
        tx_pin        = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_src_valid) begin
                    tx_shift_nxt = tx_src_data;
                    tx_cnt_nxt   = CNT_ZERO;
                    tx_bit_nxt   = 3'd0;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                tx_pin = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = CNT_ZERO;
                    tx_state_nxt = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                tx_pin = tx_shift[0];
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = CNT_ZERO;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    tx_bit_nxt   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = CNT_ZERO;
                    tx_state_nxt = TX_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rxtx.sv
// ============================================================================
// tb_uart_rxtx
// ----------------------------------------------------------------------------
// Self-checking bench for uart_rxtx at the default parameters (260 clocks per
// bit). The expected line waveforms and received bytes come from a
// frame-level model: a frame is {0, data LSB first, 1}, and each level is
// held for CYCLE clocks.
// ============================================================================
module tb_uart_rxtx;

    localparam int CLK_FRE   = 30;
    localparam int BAUD_RATE = 115200;
    localparam int CYCLE     = (CLK_FRE * 1000000) / BAUD_RATE;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       tx_pin;

    logic       rx_drive;
    logic       loop_mode;

    int total = 0;
    int bad   = 0;

    int         cyc = 0;
    int         pulse_cnt = 0;
    int         last_pulse_cyc = 0;
    logic [7:0] last_seen = 8'h00;

    always #5 clk = ~clk;

    // Either the bench drives the receiver, or the transmitter is looped
    // back into it externally.
    assign rx_pin = loop_mode ? tx_pin : rx_drive;

    uart_rxtx #(
        .CLK_FRE   (CLK_FRE),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_pin        (tx_pin)
`ifdef UART_LOOPBACK_EN
        ,
        .loopback      (1'b0)
`endif
    );

    // Free-running cycle count, used for latency measurement.
    always @(posedge clk) cyc++;

    // Records every accepted byte as the consumer sees it.
    always @(negedge clk) begin
        if (rx_data_valid && rx_data_ready) begin
            pulse_cnt++;
            last_seen      = rx_data;
            last_pulse_cyc = cyc;
        end
    end

    // Overall time limit, so the run always ends.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit hit, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drives one 8N1 frame on rx_drive, starting at a negedge. The stop bit
    // level is selectable so that framing errors can be produced.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                 output int start_cyc);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_drive = frame[i];
            repeat (CYCLE) @(negedge clk);
        end
        rx_drive = 1'b1;
    endtask

    // Offers one byte to the transmitter and checks the emitted frame clock
    // by clock against the model. It returns at the negedge where ready has
    // come back, so a following call is a back-to-back accept.
    task automatic sendTxByte(input logic [7:0] b, input logic loop_check);
        logic [9:0] frame;
        int   waited;
        int   base;
        logic bit_ok;
        logic rdy_ok;
        frame  = {1'b1, b, 1'b0};
        waited = 0;
        while (!tx_data_ready && waited < 30 * CYCLE) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_data_ready) begin
            checkOutput("tx ready wait", 32'(tx_data_ready), 32'd1);
            return;
        end
        base = pulse_cnt;
        tx_data       = b;
        tx_data_valid = 1'b1;
        @(negedge clk);
        checkOutput("tx ready drop", 32'(tx_data_ready), 32'd0);
        tx_data_valid = 1'b0;
        tx_data       = 8'($urandom);
        rdy_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bit_ok = 1'b1;
            for (int j = 0; j < CYCLE; j++) begin
                if (i > 0 || j > 0) @(negedge clk);
                if (tx_pin !== frame[i]) bit_ok = 1'b0;
                if (tx_data_ready !== 1'b0) rdy_ok = 1'b0;
            end
            checkOutput($sformatf("tx bit %0d of %0h", i, b), 32'(bit_ok), 32'd1);
        end
        checkOutput("tx ready low whole frame", 32'(rdy_ok), 32'd1);
        @(negedge clk);
        checkOutput("tx ready return", 32'(tx_data_ready), 32'd1);
        checkOutput("tx idle line", 32'(tx_pin), 32'd1);
        if (loop_check) begin
            checkOutput("loop rx count", 32'(pulse_cnt - base), 32'd1);
            checkOutput("loop rx data", 32'(last_seen), 32'(b));
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_pulses;
        logic [7:0] exp_data;
    } rx_vec_t;

    initial begin
        rx_vec_t    vecs[6];
        logic [7:0] rnd;
        int         base;
        int         start_cyc;
        int         lat;

        rnd = 8'($urandom);
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 0, 8'hA5};
        vecs[2] = '{8'h81, 1'b1, 1, 8'h81};
        vecs[3] = '{8'h00, 1'b1, 1, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF};
        vecs[5] = '{rnd,   1'b1, 1, rnd};

        reset         = 1'b1;
        rx_drive      = 1'b1;
        loop_mode     = 1'b0;
        rx_data_ready = 1'b1;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset tx_pin", 32'(tx_pin), 32'd1);
        checkOutput("reset tx_ready", 32'(tx_data_ready), 32'd1);
        checkOutput("reset rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset rx_valid", 32'(rx_data_valid), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // A short low pulse is rejected at the half-bit re-check.
        base = pulse_cnt;
        rx_drive = 1'b0;
        repeat (100) @(negedge clk);
        rx_drive = 1'b1;
        repeat (2 * CYCLE) @(negedge clk);
        checkOutput("glitch no pulse", 32'(pulse_cnt - base), 32'd0);
        checkOutput("glitch rx_valid", 32'(rx_data_valid), 32'd0);

        // Receive table: good frames, a framing error, and recovery.
        for (int v = 0; v < 6; v++) begin
            base = pulse_cnt;
            applyStimulus(vecs[v].data, vecs[v].stop_bit, start_cyc);
            repeat (CYCLE) @(negedge clk);
            checkOutput($sformatf("rx pulses vec %0d", v), 32'(pulse_cnt - base),
                        32'(vecs[v].exp_pulses));
            checkOutput($sformatf("rx_data vec %0d", v), 32'(rx_data), 32'(vecs[v].exp_data));
            if (v == 0) begin
                lat = last_pulse_cyc - start_cyc;
                checkOutput("rx latency near 9.5 bits + 3",
                            32'((lat >= (19 * CYCLE) / 2 - 2) && (lat <= (19 * CYCLE) / 2 + 8)),
                            32'd1);
            end
        end

        // TX 0x55 with valid held until ready drops.
        sendTxByte(8'h55, 1'b0);
        repeat (2 * CYCLE) @(negedge clk);
        checkOutput("tx no double send", 32'(tx_pin), 32'd1);

        // Reset in the middle of data bit 4 of an 0xF0 frame.
        tx_data       = 8'hF0;
        tx_data_valid = 1'b1;
        @(negedge clk);
        tx_data_valid = 1'b0;
        repeat (5 * CYCLE + CYCLE / 2) @(negedge clk);
        checkOutput("pre-reset tx busy", 32'(tx_data_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid reset tx_pin", 32'(tx_pin), 32'd1);
        checkOutput("mid reset tx_ready", 32'(tx_data_ready), 32'd1);
        checkOutput("mid reset rx_data", 32'(rx_data), 32'h00);
        reset = 1'b0;
        @(negedge clk);
        sendTxByte(8'h0F, 1'b0);

        // Overrun: two bytes with nobody consuming, then a single handshake.
        rx_data_ready = 1'b0;
        applyStimulus(8'h11, 1'b1, start_cyc);
        applyStimulus(8'h22, 1'b1, start_cyc);
        repeat (20) @(negedge clk);
        checkOutput("overrun valid", 32'(rx_data_valid), 32'd1);
        checkOutput("overrun data", 32'(rx_data), 32'h22);
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        checkOutput("valid clear after handshake", 32'(rx_data_valid), 32'd0);
        @(negedge clk);
        rx_data_ready = 1'b1;

        // Random bytes sent back to back through the transmitter and looped
        // into the receiver.
        loop_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 1) repeat ($urandom_range(0, 5)) @(negedge clk);
            sendTxByte(8'($urandom), 1'b1);
        end
        loop_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
